// File: rtl/vga_fb_fetch.sv
// vga_fb_fetch: streams one frame of RGB565 pixels from memory in fixed bursts into a FIFO
// and pops one pixel per display request. Restarts at FB_BASE on every frame_sync.
module vga_fb_fetch #(
   parameter int                ADDR_W      = 20,
   parameter logic [ADDR_W-1:0] FB_BASE     = '0,
   parameter int                FRAME_WORDS = 786432,
   parameter int                BURST_LEN   = 16,
   parameter int                FIFO_AW     = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_sync,
   input  logic              data_req,
   output logic [15:0]       dout,
   output logic              mem_rd_req,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic              mem_rd_ack,
   input  logic              mem_rd_valid,
   input  logic [15:0]       mem_rd_data,
   output logic [FIFO_AW:0]  fifo_level,
   output logic              underflow
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam int LW    = FIFO_AW + 1;
   localparam int BC_W  = $clog2(BURST_LEN);
   localparam int WL_W  = $clog2(FRAME_WORDS + 1);

   typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [WL_W-1:0]     left_q, left_d;
   logic [BC_W-1:0]     beat_q, beat_d;
   logic                pend_q, pend_d;
   logic [FIFO_AW-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [FIFO_AW:0]    level_q, level_d;
   logic [15:0]         dout_q, dout_d;
   logic                uf_q, uf_d;
   logic                restart, push, pop, last_beat;
   logic [15:0]         fifo_mem [DEPTH];

   assign last_beat = state_q == DATA && mem_rd_valid && beat_q == BC_W'(BURST_LEN - 1);
   // beats of a burst overtaken by a frame restart are dropped
   assign push = state_q == DATA && mem_rd_valid && !pend_q && !frame_sync;
   assign pop  = data_req && level_q != '0;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      left_d  = left_q;
      beat_d  = beat_q;
      pend_d  = pend_q;
      restart = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_sync) restart = 1'b1;
            else if (left_q == '0) state_d = DONE;
            else if (int'(level_q) <= DEPTH - BURST_LEN) state_d = REQ;
         end
         REQ: begin
            pend_d = pend_q | frame_sync;
            if (mem_rd_ack) begin
               state_d = DATA;
               beat_d  = '0;
            end
         end
         DATA: begin
            pend_d = pend_q | frame_sync;
            if (mem_rd_valid) beat_d = beat_q + 1'b1;
            if (last_beat) begin
               if (pend_q || frame_sync) restart = 1'b1;
               else begin
                  addr_d  = addr_q + ADDR_W'(BURST_LEN);
                  left_d  = left_q - WL_W'(BURST_LEN);
                  state_d = IDLE;
               end
            end
         end
         default: if (frame_sync) restart = 1'b1;
      endcase
      if (restart) begin
         state_d = IDLE;
         addr_d  = FB_BASE;
         left_d  = WL_W'(FRAME_WORDS);
         pend_d  = 1'b0;
      end
   end

   assign wr_d    = restart ? '0 : wr_q + FIFO_AW'(push);
   assign rd_d    = restart ? '0 : rd_q + FIFO_AW'(pop);
   assign level_d = restart ? '0 : level_q + LW'(push) - LW'(pop);
   assign dout_d  = pop ? fifo_mem[rd_q] : '0;
   assign uf_d    = restart ? 1'b0 : uf_q | (data_req && level_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DONE;
         addr_q  <= FB_BASE;
         left_q  <= '0;
         beat_q  <= '0;
         pend_q  <= 1'b0;
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
         dout_q  <= '0;
         uf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         left_q  <= left_d;
         beat_q  <= beat_d;
         pend_q  <= pend_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
         dout_q  <= dout_d;
         uf_q    <= uf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_q] <= mem_rd_data;
   end

   assign dout        = dout_q;
   assign mem_rd_req  = state_q == REQ;
   assign mem_rd_addr = addr_q;
   assign fifo_level  = level_q;
   assign underflow   = uf_q;
endmodule
